truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequencer that exhaustively drives a small combinational DUT through every input combination, waits a programmable settle time per vector, samples the DUT output and assembles the complete truth table in a register. It replaces hand-written stimulus sequences in our bring-up flow for 3-input logic blocks. It sits beside the DUT: its `dut_in` outputs drive the DUT inputs and the DUT output returns on `dut_out`. A golden table compare yields a single pass flag.

## Interface
Parameters:
- `N_IN`, 3: number of DUT inputs; sweep covers 2**N_IN vectors (legal 1..6).
- `SETTLE`, 2: extra hold cycles per vector before sampling (legal ≥1).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `abort`  in  1  synchronous cancel of a running sweep.
- `golden`  in  2**N_IN  expected table; bit i = expected output for vector i.
- `dut_in`  out  N_IN  current vector applied to the DUT (MSB = input a).
- `dut_out`  in  1  DUT response.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse when the table is complete.
- `table_q`  out  2**N_IN  captured truth table; bit i = response to vector i.
- `pass`  out  1  `table_q == golden`, updated with `done`, held until next start.

## Operation
- FSM states: IDLE, APPLY, FINISH.
- IDLE: `start`=1 → APPLY; `idx`←0, `dut_in`←0, `cnt`←0, `table_q`←0, `pass`←0, `busy`←1.
- APPLY: `cnt` increments each cycle. When `cnt`==SETTLE: `table_q[idx]`←`dut_out`.
  - If `idx`==2**N_IN−1 → FINISH, `busy`←0, `done`←1, `pass`←(captured table incl. this bit == `golden`).
  - Otherwise `idx`←`idx`+1, `dut_in`←`idx`+1, `cnt`←0.
- FINISH: one cycle, `done` deasserts on exit → IDLE.
- `abort` in APPLY → IDLE next edge. `busy`←0, no `done`, `pass` stays 0, `table_q` keeps the partial capture. `abort` is ignored in IDLE and FINISH. If `abort` and the final sample land on the same cycle, `abort` wins.
- `start` during APPLY or FINISH is ignored. It is not queued.
- `golden` is sampled only on the final-sample edge.
- Widths: `idx` is N_IN bits and never wraps (the sweep stops at all-ones). `cnt` is $clog2(SETTLE+1) bits.

## Timing
- Reset values: `dut_in`=0, `busy`=0, `done`=0, `table_q`=0, `pass`=0, state IDLE. Reset is effective immediately, including mid-sweep.
- Each vector is held for exactly SETTLE+1 cycles. `dut_out` is sampled on the last of these.
- Start accepted on edge k → vector i is sampled at edge k+(i+1)(SETTLE+1) → `done` is high in the cycle following edge k+2**N_IN·(SETTLE+1).
- Defaults: 24 APPLY cycles and `done` after edge k+24.
- `table_q`/`pass` are stable whenever `done`=1 and remain so until the next accepted start.
- A new start is accepted in the cycle after FINISH (IDLE) at the earliest.

## Structure
- Shared package `sweep_pkg`: state enum (IDLE, APPLY, FINISH) and the default N_IN/SETTLE constants.
- One natural sub-module: `settle_counter` (load/clear, increment, terminal flag at SETTLE), reusable by the ROM/RAM access sequencers.
- No other hierarchy.

## Test plan
- Defaults, DUT = majority(a,b,c), `golden`=8'b1110_1000 → `dut_in` steps 0..7 every 3 cycles, `done` pulses 24 cycles after start, `table_q`=8'hE8, `pass`=1.
- Same DUT, `golden`=8'hE9 → `table_q`=8'hE8, `pass`=0.
- `abort` asserted on the 10th APPLY cycle → `busy` low next edge, no `done`, `table_q`=8'b0000_0000 for bits 0..2 sampled (majority gives 0,0,0), `pass`=0.
- `start` held high throughout a sweep → exactly one `done` per sweep. Second sweep starts in the IDLE cycle after FINISH, and `table_q` clears at that start.
- `rst_n` pulsed low mid-sweep (vector 4) → all outputs 0 asynchronously, FSM in IDLE, next `start` sweeps normally from vector 0.
- SETTLE=1, N_IN=2, DUT = XOR(a,b), `golden`=4'b0110 → 8 APPLY cycles, `table_q`=4'h6, `pass`=1.

Source files
------------

// File: rtl/sweep_pkg.sv
// sweep_pkg: shared sweep FSM states and default sweep geometry
package sweep_pkg;
    typedef enum logic [1:0] {IDLE, APPLY, FINISH} state_t;
    localparam int N_IN_DEF   = 3;
    localparam int SETTLE_DEF = 2;
endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: host control/status plus DUT stimulus/response bundle
interface truth_table_sweeper_if #(parameter int N_IN = 3) ();
    localparam int V = 1 << N_IN;
    logic            start;
    logic            abort;
    logic [V-1:0]    golden;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic [V-1:0]    table_q;
    logic            pass;
    modport master (output start, abort, golden, dut_out, input dut_in, busy, done, table_q, pass);
    modport slave  (input start, abort, golden, dut_out, output dut_in, busy, done, table_q, pass);
endinterface

// File: rtl/truth_table_sweeper_settle_counter.sv
// settle_counter: per-vector hold counter, terminal flag once SETTLE extra cycles have elapsed
module settle_counter #(parameter int SETTLE = 2) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic term
);
    localparam int CW = $clog2(SETTLE + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    assign term = cnt == CW'(SETTLE);
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector of a small combinational DUT and
// captures its truth table, comparing it against a golden table at the end
module truth_table_sweeper import sweep_pkg::*; #(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    truth_table_sweeper_if.slave  bus
);
    localparam int V = 1 << N_IN;
    state_t          state, state_nx;
    logic [N_IN-1:0] idx;
    logic [V-1:0]    cap;
    logic            term, last;
    settle_counter #(.SETTLE(SETTLE)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != APPLY || term),
        .inc   (state == APPLY),
        .term  (term)
    );
    assign last       = &idx;
    assign bus.dut_in = idx;
    always_comb begin
        state_nx = state;
        cap      = bus.table_q;
        cap[idx] = bus.dut_out;
        if (state == IDLE) state_nx = bus.start ? APPLY : IDLE;
        else if (state == APPLY) state_nx = bus.abort ? IDLE : (term && last) ? FINISH : APPLY;
        else state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // abort takes priority over a coinciding sample, so the partial table is kept as-is
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx         <= '0;
            bus.table_q <= '0;
            bus.pass    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE && bus.start) begin
                idx         <= '0;
                bus.table_q <= '0;
                bus.pass    <= 1'b0;
                bus.busy    <= 1'b1;
            end else if (state == APPLY) begin
                if (bus.abort) bus.busy <= 1'b0;
                else if (term) begin
                    bus.table_q <= cap;
                    if (last) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= cap == bus.golden;
                    end else idx <= idx + 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed and randomized sweeps of both a 3-input/SETTLE=2
// and a 2-input/SETTLE=1 sweeper against a behavioural truth-table model
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    truth_table_sweeper_if #(.N_IN(3)) b0 ();
    truth_table_sweeper_if #(.N_IN(2)) b1 ();
    logic [7:0] rsp0 = '0;
    logic [3:0] rsp1 = '0;
    assign b0.dut_out = rsp0[b0.dut_in];
    assign b1.dut_out = rsp1[b1.dut_in];
    truth_table_sweeper u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    int tests = 0;
    int fails = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [7:0] maj_tbl();
        logic [7:0] t;
        for (int v = 0; v < 8; v++) t[v] = $countones(v[2:0]) >= 2;
        return t;
    endfunction
    function automatic logic [3:0] xor_tbl();
        logic [3:0] t;
        for (int v = 0; v < 4; v++) t[v] = $countones(v[1:0]) == 1;
        return t;
    endfunction
    // each vector is held 3 cycles; golden is scrambled until just before the final sample
    task automatic sweep0(input logic [7:0] tbl, input logic [7:0] gold);
        rsp0 = tbl;
        b0.golden = gold;
        b0.start = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0;
        for (int j = 0; j < 24; j++) begin
            b0.golden = (j == 23) ? gold : ~gold;
            chk("dut_in0", b0.dut_in, j / 3);
            chk("busy0", b0.busy, 1);
            chk("done0_early", b0.done, 0);
            @(posedge clk); #1;
        end
        chk("done0", b0.done, 1);
        chk("busy0_end", b0.busy, 0);
        chk("table0", b0.table_q, tbl);
        chk("pass0", b0.pass, tbl == gold);
        b0.golden = ~gold;
        @(posedge clk); #1;
        chk("done0_drop", b0.done, 0);
        chk("table0_hold", b0.table_q, tbl);
        chk("pass0_hold", b0.pass, tbl == gold);
    endtask
    task automatic sweep1(input logic [3:0] tbl, input logic [3:0] gold);
        rsp1 = tbl;
        b1.golden = gold;
        b1.start = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk("dut_in1", b1.dut_in, j / 2);
            chk("done1_early", b1.done, 0);
            @(posedge clk); #1;
        end
        chk("done1", b1.done, 1);
        chk("table1", b1.table_q, tbl);
        chk("pass1", b1.pass, tbl == gold);
        @(posedge clk); #1;
    endtask
    // abort raised during APPLY cycle c (1-based); only vectors sampled before that edge survive
    task automatic abort0(input logic [7:0] tbl, input int c);
        int n, dn;
        n = (c - 1) / 3;
        rsp0 = tbl;
        b0.golden = tbl;
        b0.start = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0;
        repeat (c - 1) begin @(posedge clk); #1; end
        b0.abort = 1'b1;
        @(posedge clk); #1;
        b0.abort = 1'b0;
        chk("abort_busy", b0.busy, 0);
        chk("abort_table", b0.table_q, tbl & 8'((1 << n) - 1));
        chk("abort_pass", b0.pass, 0);
        dn = 0;
        repeat (30) begin
            if (b0.done) dn++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", dn, 0);
    endtask
    initial begin
        logic [7:0] t8, g8;
        logic [3:0] t4;
        int dn;
        b0.start = 1'b0; b0.abort = 1'b0; b0.golden = '0;
        b1.start = 1'b0; b1.abort = 1'b0; b1.golden = '0;
        #3;
        chk("rst_dut_in", b0.dut_in, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_done", b0.done, 0);
        chk("rst_table", b0.table_q, 0);
        chk("rst_pass", b0.pass, 0);
        chk("rst_table1", b1.table_q, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        sweep0(maj_tbl(), 8'hE8);
        sweep0(maj_tbl(), 8'hE9);
        for (int r = 0; r < 4; r++) begin
            t8 = 8'($urandom);
            g8 = $urandom_range(0, 1) ? t8 : t8 ^ 8'(1 << $urandom_range(0, 7));
            sweep0(t8, g8);
        end
        abort0(maj_tbl(), 10);
        abort0(8'hFF, 24);
        abort0(8'($urandom), int'($urandom_range(1, 23)));
        rsp0 = maj_tbl();
        b0.golden = 8'hE8;
        b0.start = 1'b1;
        @(posedge clk); #1;
        dn = 0;
        for (int j = 1; j <= 50; j++) begin
            @(posedge clk); #1;
            if (b0.done) dn++;
            if (j == 26) begin
                chk("restart_table", b0.table_q, 0);
                chk("restart_busy", b0.busy, 1);
            end
        end
        b0.start = 1'b0;
        chk("held_start_dones", dn, 2);
        chk("held_start_table", b0.table_q, 8'hE8);
        chk("held_start_pass", b0.pass, 1);
        @(posedge clk); #1;
        b0.start = 1'b1;
        @(posedge clk); #1;
        b0.start = 1'b0;
        repeat (13) begin @(posedge clk); #1; end
        chk("pre_rst_vec", b0.dut_in, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dut_in", b0.dut_in, 0);
        chk("mid_rst_busy", b0.busy, 0);
        chk("mid_rst_done", b0.done, 0);
        chk("mid_rst_table", b0.table_q, 0);
        chk("mid_rst_pass", b0.pass, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        sweep0(maj_tbl(), 8'hE8);
        sweep1(xor_tbl(), 4'b0110);
        for (int r = 0; r < 3; r++) begin
            t4 = 4'($urandom);
            sweep1(t4, $urandom_range(0, 1) ? t4 : ~t4);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
